// File: rtl/zint_mc.sv
// Multi-channel Z80 IM2 interrupt controller: per-channel pending flags with priority
// acknowledge, optional self-clearing pulse channels and VDOS suppression.
module zint_mc #(
    parameter int unsigned    NCH          = 3,
    parameter logic [7:0]     VEC_BASE     = 8'hFF,
    parameter int unsigned    PULSE_LEN    = 32,
    parameter logic [NCH-1:0] AUTOCLR_MASK = NCH'('b001),
    parameter logic [NCH-1:0] LOST_MASK    = NCH'('b011)
) (
    input  logic           clk,
    input  logic           res_n,
    input  logic           zpos,
    input  logic [NCH-1:0] int_start,
    input  logic [NCH-1:0] intmask,
    input  logic [NCH-1:0] int_clr,
    input  logic           vdos,
    input  logic           intack,
    output logic [7:0]     im2vect,
    output logic           int_n,
    output logic [NCH-1:0] int_pend
);

    localparam logic [5:0] PLEN = 6'(PULSE_LEN);

    logic           intack_q;
    logic           intack_s;
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] start_ok;
    logic [NCH-1:0] first_oh;
    logic [NCH-1:0] at_limit;
    logic [7:0]     vec_q;
    logic [7:0]     vec_d;
    logic [7:0]     vec_sel;

    assign intack_s = intack & ~intack_q;
    assign start_ok = intmask & int_start & ~({NCH{vdos}} & LOST_MASK);
    // Isolate the lowest set bit: the highest-priority pending channel.
    assign first_oh = pend_q & (~pend_q + NCH'(1));

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            intack_q <= 1'b0;
            pend_q   <= '0;
            vec_q    <= VEC_BASE;
        end else begin
            intack_q <= intack;
            pend_q   <= pend_d;
            vec_q    <= vec_d;
        end
    end

    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NCH; i++) begin
            if (!intmask[i]) begin
                pend_d[i] = 1'b0;
            end else if (start_ok[i]) begin
                pend_d[i] = 1'b1;
            end else if (int_clr[i] || (intack_s && first_oh[i]) || at_limit[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        vec_sel = VEC_BASE;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                vec_sel = VEC_BASE - 8'(2 * i);
            end
        end
        vec_d = vec_q;
        if (intack_s && (|pend_q)) begin
            vec_d = vec_sel;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        if (AUTOCLR_MASK[g]) begin : g_cnt
            logic [5:0] cnt_q;

            // Saturating pulse-length counter; frozen while VDOS is active.
            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    cnt_q <= '0;
                end else if (start_ok[g]) begin
                    cnt_q <= '0;
                end else if (zpos && pend_q[g] && !vdos && (cnt_q < PLEN)) begin
                    cnt_q <= cnt_q + 6'd1;
                end
            end

            assign at_limit[g] = (cnt_q == PLEN);
        end else begin : g_nocnt
            assign at_limit[g] = 1'b0;
        end
    end

    assign im2vect  = vec_q;
    assign int_pend = pend_q;
    assign int_n    = ~(|pend_q) | vdos;

endmodule

// File: tb/tb_zint_mc.sv
// Randomized and directed checks of zint_mc against a behavioural reference model.
module tb_zint_mc;

    localparam int NCH = 3;
    localparam int PULSE = 32;
    localparam bit [2:0] AUTOCLR = 3'b001;
    localparam bit [2:0] LOST = 3'b011;

    logic       clk = 1'b0;
    logic       res_n;
    logic       zpos;
    logic [2:0] int_start;
    logic [2:0] intmask;
    logic [2:0] int_clr;
    logic       vdos;
    logic       intack;
    logic [7:0] im2vect;
    logic       int_n;
    logic [2:0] int_pend;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model state
    bit m_pend [NCH];
    int m_cnt [NCH];
    bit m_ack_prev;
    int m_vec;

    zint_mc dut (
        .clk       (clk),
        .res_n     (res_n),
        .zpos      (zpos),
        .int_start (int_start),
        .intmask   (intmask),
        .int_clr   (int_clr),
        .vdos      (vdos),
        .intack    (intack),
        .im2vect   (im2vect),
        .int_n     (int_n),
        .int_pend  (int_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = 1'b0;
            m_cnt[i]  = 0;
        end
        m_ack_prev = 1'b0;
        m_vec      = 255;
    endtask

    // One clock edge of the rules, using the inputs present at that edge.
    task automatic model_step();
        bit ack_rise;
        int hi;
        bit old_pend [NCH];
        ack_rise = intack && !m_ack_prev;
        hi = -1;
        for (int i = NCH - 1; i >= 0; i--) if (m_pend[i]) hi = i;
        old_pend = m_pend;
        for (int i = 0; i < NCH; i++) begin
            bit accepted;
            bit clear;
            accepted = intmask[i] && int_start[i] && !(vdos && LOST[i]);
            clear = int_clr[i] || (ack_rise && hi == i) || (AUTOCLR[i] && m_cnt[i] == PULSE);
            if (!intmask[i]) m_pend[i] = 1'b0;
            else if (accepted) m_pend[i] = 1'b1;
            else if (clear) m_pend[i] = 1'b0;
            if (AUTOCLR[i]) begin
                if (accepted) m_cnt[i] = 0;
                else if (zpos && old_pend[i] && !vdos && m_cnt[i] < PULSE) m_cnt[i]++;
            end
        end
        if (ack_rise && hi >= 0) m_vec = (255 - 2 * hi) % 256;
        m_ack_prev = intack;
    endtask

    function automatic logic [2:0] exp_pend();
        logic [2:0] p;
        for (int i = 0; i < NCH; i++) p[i] = m_pend[i];
        return p;
    endfunction

    task automatic compare_all();
        logic [2:0] p;
        p = exp_pend();
        check("int_pend", 32'(int_pend), 32'(p));
        check("im2vect", 32'(im2vect), 32'(m_vec));
        check("int_n", 32'(int_n), 32'(!(|p) || vdos));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        int_start = '0;
        int_clr   = '0;
        zpos      = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            idle();
        end
    endtask

    initial begin
        res_n = 1'b0;
        intmask = 3'b111;
        vdos = 1'b0;
        intack = 1'b0;
        idle();
        model_reset();
        #12;
        check("reset_int_n", 32'(int_n), 32'd1);
        check("reset_vec", 32'(im2vect), 32'hFF);
        check("reset_pend", 32'(int_pend), 32'd0);
        res_n = 1'b1;
        run(2);

        // Auto-clear pulse: 32 zpos ticks, one every 4 clocks
        int_start = 3'b001;
        run(1);
        for (int i = 0; i < 4 * PULSE + 8; i++) begin
            zpos = (i % 4 == 3);
            cyc();
            idle();
        end
        check("pulse_end_pend", 32'(int_pend), 32'd0);
        check("pulse_end_int_n", 32'(int_n), 32'd1);

        // Priority acknowledge
        int_start = 3'b110;
        run(1);
        intack = 1'b1;
        run(1);
        intack = 1'b0;
        run(1);
        check("ack1_vec", 32'(im2vect), 32'hFD);
        check("ack1_pend", 32'(int_pend), 32'b100);
        intack = 1'b1;
        run(1);
        intack = 1'b0;
        run(1);
        check("ack2_vec", 32'(im2vect), 32'hFB);
        check("ack2_pend", 32'(int_pend), 32'b000);

        // VDOS: lost vs held channels
        vdos = 1'b1;
        int_start = 3'b111;
        run(2);
        check("vdos_int_n", 32'(int_n), 32'd1);
        check("vdos_pend", 32'(int_pend), 32'b100);
        vdos = 1'b0;
        #1;
        check("vdos_fall_int_n", 32'(int_n), 32'd0);
        intack = 1'b1;
        run(1);
        intack = 1'b0;
        run(1);
        check("vdos_ack_vec", 32'(im2vect), 32'hFB);

        // Start beats clear in the same cycle
        int_start = 3'b010;
        int_clr = 3'b010;
        run(1);
        check("start_wins", 32'(int_pend), 32'b010);
        int_clr = 3'b010;
        run(1);
        check("clr_after", 32'(int_pend), 32'b000);

        // Held intack clears only once
        int_start = 3'b101;
        run(1);
        intack = 1'b1;
        run(10);
        intack = 1'b0;
        check("held_ack_pend", 32'(int_pend), 32'b100);
        check("held_ack_vec", 32'(im2vect), 32'hFF);
        intmask = 3'b110;
        int_start = 3'b001;
        run(2);
        check("masked_start", 32'(int_pend[0]), 32'd0);
        intmask = 3'b111;
        int_clr = 3'b100;
        run(1);

        // Reset mid-pulse, between clock edges
        int_start = 3'b001;
        run(3);
        #3;
        res_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_int_n", 32'(int_n), 32'd1);
        check("async_rst_vec", 32'(im2vect), 32'hFF);
        check("async_rst_pend", 32'(int_pend), 32'd0);
        intack = 1'b1;
        #2;
        res_n = 1'b1;
        run(2);
        intack = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NCH; b++) begin
                int_start[b] = ($urandom_range(0, 15) == 0);
                int_clr[b]   = ($urandom_range(0, 31) == 0);
            end
            zpos = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) intack = ~intack;
            if ($urandom_range(0, 59) == 0) vdos = ~vdos;
            if ($urandom_range(0, 79) == 0)
                intmask = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
